// File: rtl/cmd_parser.sv
// Parses MAGIC-prefixed frames of 5-byte {addr, data[31:0]} records into register writes.
// Write strobe 1 clock after the last record byte; every valid byte is accepted, no back-pressure.
module cmd_parser #(
  parameter logic [7:0] MAGIC = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_sop,
  input  logic        i_rx_eop,
  output logic [7:0]  o_cmd_addr,
  output logic [31:0] o_cmd_data,
  output logic        o_cmd_wr,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_err_cnt,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    D3   = 3'd2,
    D2   = 3'd3,
    D1   = 3'd4,
    D0   = 3'd5,
    DROP = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [23:0] data_q, data_d;
  logic [7:0]  cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_data_q, cmd_data_d;
  logic        cmd_wr_q, cmd_wr_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        err_abort;
  logic        err_bad;
  logic        frame_inc;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      cmd_wr_q    <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_wr_q    <= cmd_wr_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    cmd_wr_d   = 1'b0;
    err_abort  = 1'b0;
    err_bad    = 1'b0;
    frame_inc  = 1'b0;

    if (i_rx_valid) begin
      if (i_rx_sop) begin
        // A sop always restarts parsing; an interrupted frame is an error of its own.
        err_abort = (state_q != IDLE);
        if (i_rx_data == MAGIC) begin
          frame_inc = i_rx_eop;
          state_d   = i_rx_eop ? IDLE : ADDR;
        end else begin
          err_bad = 1'b1;
          state_d = i_rx_eop ? IDLE : DROP;
        end
      end else begin
        case (state_q)
          IDLE: state_d = IDLE;
          ADDR: begin
            if (i_rx_eop) begin
              frame_inc = 1'b1;
              state_d   = IDLE;
            end else begin
              addr_d  = i_rx_data;
              state_d = D3;
            end
          end
          D3: begin
            data_d[23:16] = i_rx_data;
            err_bad       = i_rx_eop;
            state_d       = i_rx_eop ? IDLE : D2;
          end
          D2: begin
            data_d[15:8] = i_rx_data;
            err_bad      = i_rx_eop;
            state_d      = i_rx_eop ? IDLE : D1;
          end
          D1: begin
            data_d[7:0] = i_rx_data;
            err_bad     = i_rx_eop;
            state_d     = i_rx_eop ? IDLE : D0;
          end
          D0: begin
            cmd_wr_d   = 1'b1;
            cmd_addr_d = addr_q;
            cmd_data_d = {data_q, i_rx_data};
            frame_inc  = i_rx_eop;
            state_d    = i_rx_eop ? IDLE : ADDR;
          end
          DROP:    state_d = i_rx_eop ? IDLE : DROP;
          default: state_d = IDLE;
        endcase
      end
    end

    // Abort plus bad magic on the same sop byte counts twice.
    err_inc   = {1'b0, err_abort} + {1'b0, err_bad};
    err_sum   = {1'b0, err_cnt_q} + {15'd0, err_inc};
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    frame_cnt_d = (frame_inc && (frame_cnt_q != 16'hFFFF)) ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  assign o_cmd_addr  = cmd_addr_q;
  assign o_cmd_data  = cmd_data_q;
  assign o_cmd_wr    = cmd_wr_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cmd_parser.sv
// Directed bench for cmd_parser: hand-computed strobes and counter values per scenario.
module tb_cmd_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sop;
  logic        rx_eop;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_wr;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  logic [39:0] wr_log[$];

  always #5 clk = ~clk;

  cmd_parser #(.MAGIC(8'hA5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .i_rx_sop    (rx_sop),
    .i_rx_eop    (rx_eop),
    .o_cmd_addr  (cmd_addr),
    .o_cmd_data  (cmd_data),
    .o_cmd_wr    (cmd_wr),
    .o_frame_cnt (frame_cnt),
    .o_err_cnt   (err_cnt),
    .o_busy      (busy)
  );

  // Strobe monitor samples just after the active edge.
  always @(posedge clk) begin
    #1;
    if (cmd_wr === 1'b1) begin
      wr_seen++;
      wr_log.push_back({cmd_addr, cmd_data});
    end
  end

  task automatic drive(input logic [7:0] d, input logic s, input logic e);
    @(negedge clk);
    rx_data  = d;
    rx_valid = 1'b1;
    rx_sop   = s;
    rx_eop   = e;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_sop   = 1'b0;
      rx_eop   = 1'b0;
      rx_data  = 8'h00;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_data = 8'h00;
    #12;
    checks++;
    if ({cmd_wr, busy, cmd_addr, cmd_data, frame_cnt, err_cnt} !== 74'd0) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%b busy=%b addr=%h data=%h fc=%h ec=%h, expected all zero",
               cmd_wr, busy, cmd_addr, cmd_data, frame_cnt, err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    gap(2);
  endtask

  task automatic test_single_record();
    int base = wr_seen;
    drive(8'hA5, 1, 0); drive(8'h18, 0, 0); drive(8'h11, 0, 0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    drive(8'h22, 0, 0); drive(8'h33, 0, 0); drive(8'h44, 0, 1);
    gap(1);
    checks++;
    if (cmd_wr !== 1'b1 || cmd_addr !== 8'h18 || cmd_data !== 32'h11223344) begin
      errors++;
      $display("FAIL single_strobe: got wr=%b addr=%h data=%h expected wr=1 addr=18 data=11223344",
               cmd_wr, cmd_addr, cmd_data);
    end
    checks++;
    if (frame_cnt !== 16'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_frame_cnt: got fc=%0d busy=%b expected fc=1 busy=0", frame_cnt, busy);
    end
    gap(2);
    checks++;
    if (cmd_wr !== 1'b0 || cmd_addr !== 8'h18 || cmd_data !== 32'h11223344 || wr_seen - base != 1) begin
      errors++;
      $display("FAIL single_hold: got wr=%b addr=%h data=%h strobes=%0d expected wr=0 addr=18 data=11223344 strobes=1",
               cmd_wr, cmd_addr, cmd_data, wr_seen - base);
    end
  endtask

  task automatic test_gapped_records();
    int base = wr_seen;
    drive(8'hA5, 1, 0); gap(2);
    drive(8'h28, 0, 0); drive(8'hC0, 0, 0); gap(1);
    drive(8'hA8, 0, 0); drive(8'h00, 0, 0); gap(3);
    drive(8'h01, 0, 0); drive(8'h02, 0, 0); drive(8'h00, 0, 0); gap(1);
    drive(8'h00, 0, 0); drive(8'h00, 0, 0); drive(8'h01, 0, 1);
    gap(2);
    checks++;
    if (wr_seen - base != 2) begin
      errors++; $display("FAIL gapped_count: got %0d strobes expected 2", wr_seen - base);
    end else begin
      checks++;
      if (wr_log[wr_log.size()-2] !== {8'h28, 32'hC0A80001} || wr_log[wr_log.size()-1] !== {8'h02, 32'h00000001}) begin
        errors++;
        $display("FAIL gapped_order: got %h then %h expected 28c0a80001 then 0200000001",
                 wr_log[wr_log.size()-2], wr_log[wr_log.size()-1]);
      end
    end
    checks++;
    if (frame_cnt !== 16'd2 || err_cnt !== 16'd0) begin
      errors++; $display("FAIL gapped_counts: got fc=%0d ec=%0d expected fc=2 ec=0", frame_cnt, err_cnt);
    end
  endtask

  task automatic test_bad_magic();
    int base = wr_seen;
    drive(8'h5A, 1, 0); drive(8'h01, 0, 0); drive(8'h02, 0, 0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bad_magic_drop_busy: got %b expected 1", busy); end
    drive(8'h03, 0, 1);
    gap(1);
    checks++;
    if (err_cnt !== 16'd1 || busy !== 1'b0 || wr_seen != base) begin
      errors++;
      $display("FAIL bad_magic: got ec=%0d busy=%b strobes=%0d expected ec=1 busy=0 strobes=0",
               err_cnt, busy, wr_seen - base);
    end
    drive(8'hA5, 1, 0); drive(8'h40, 0, 0); drive(8'hDE, 0, 0);
    drive(8'hAD, 0, 0); drive(8'hBE, 0, 0); drive(8'hEF, 0, 1);
    gap(1);
    checks++;
    if (cmd_wr !== 1'b1 || cmd_addr !== 8'h40 || cmd_data !== 32'hDEADBEEF || frame_cnt !== 16'd3) begin
      errors++;
      $display("FAIL after_bad_magic: got wr=%b addr=%h data=%h fc=%0d expected wr=1 addr=40 data=deadbeef fc=3",
               cmd_wr, cmd_addr, cmd_data, frame_cnt);
    end
  endtask

  task automatic test_truncated();
    int base;
    gap(1);
    base = wr_seen;
    drive(8'hA5, 1, 0); drive(8'h30, 0, 0); drive(8'h01, 0, 0); drive(8'h02, 0, 1);
    gap(1);
    checks++;
    if (err_cnt !== 16'd2 || busy !== 1'b0 || wr_seen != base || frame_cnt !== 16'd3) begin
      errors++;
      $display("FAIL truncated: got ec=%0d busy=%b strobes=%0d fc=%0d expected ec=2 busy=0 strobes=0 fc=3",
               err_cnt, busy, wr_seen - base, frame_cnt);
    end
  endtask

  task automatic test_mid_sop();
    int base = wr_seen;
    drive(8'hA5, 1, 0); drive(8'h50, 0, 0); drive(8'h12, 0, 0); drive(8'h34, 0, 0);
    drive(8'hA5, 1, 0); drive(8'h60, 0, 0); drive(8'h01, 0, 0);
    drive(8'h02, 0, 0); drive(8'h03, 0, 0); drive(8'h04, 0, 1);
    gap(1);
    checks++;
    if (cmd_addr !== 8'h60 || cmd_data !== 32'h01020304 || wr_seen - base != 1) begin
      errors++;
      $display("FAIL mid_sop_record: got addr=%h data=%h strobes=%0d expected addr=60 data=01020304 strobes=1",
               cmd_addr, cmd_data, wr_seen - base);
    end
    checks++;
    if (err_cnt !== 16'd3 || frame_cnt !== 16'd4) begin
      errors++; $display("FAIL mid_sop_counts: got ec=%0d fc=%0d expected ec=3 fc=4", err_cnt, frame_cnt);
    end
  endtask

  task automatic test_double_err_and_no_revoke();
    int base;
    drive(8'hA5, 1, 0); drive(8'h70, 0, 0); drive(8'h5A, 1, 0); drive(8'h00, 0, 1);
    gap(1);
    checks++;
    if (err_cnt !== 16'd5 || busy !== 1'b0) begin
      errors++; $display("FAIL double_err: got ec=%0d busy=%b expected ec=5 busy=0", err_cnt, busy);
    end
    base = wr_seen;
    drive(8'hA5, 1, 0); drive(8'h11, 0, 0); drive(8'hAA, 0, 0); drive(8'hBB, 0, 0);
    drive(8'hCC, 0, 0); drive(8'hDD, 0, 0); drive(8'h22, 0, 0); drive(8'h01, 0, 1);
    gap(2);
    checks++;
    if (wr_seen - base != 1 || cmd_addr !== 8'h11 || cmd_data !== 32'hAABBCCDD ||
        err_cnt !== 16'd6 || frame_cnt !== 16'd4) begin
      errors++;
      $display("FAIL no_revoke: got strobes=%0d addr=%h data=%h ec=%0d fc=%0d expected 1 11 aabbccdd 6 4",
               wr_seen - base, cmd_addr, cmd_data, err_cnt, frame_cnt);
    end
  endtask

  task automatic test_clean_ends();
    int base;
    drive(8'hA5, 1, 1);
    gap(1);
    checks++;
    if (frame_cnt !== 16'd5 || busy !== 1'b0 || err_cnt !== 16'd6) begin
      errors++; $display("FAIL lone_magic: got fc=%0d busy=%b ec=%0d expected 5 0 6", frame_cnt, busy, err_cnt);
    end
    base = wr_seen;
    drive(8'hA5, 1, 0); drive(8'h01, 0, 0); drive(8'h00, 0, 0); drive(8'h00, 0, 0);
    drive(8'h00, 0, 0); drive(8'h05, 0, 0); drive(8'h99, 0, 1);
    gap(1);
    checks++;
    if (frame_cnt !== 16'd6 || wr_seen - base != 1 || cmd_data !== 32'h00000005 || busy !== 1'b0) begin
      errors++;
      $display("FAIL eop_in_addr: got fc=%0d strobes=%0d data=%h busy=%b expected 6 1 00000005 0",
               frame_cnt, wr_seen - base, cmd_data, busy);
    end
    drive(8'hA5, 0, 0); drive(8'h77, 0, 1);
    gap(1);
    checks++;
    if (busy !== 1'b0 || frame_cnt !== 16'd6 || err_cnt !== 16'd6) begin
      errors++; $display("FAIL idle_no_sop: got busy=%b fc=%0d ec=%0d expected 0 6 6", busy, frame_cnt, err_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base = wr_seen;
    drive(8'hA5, 1, 0); drive(8'h80, 0, 0); drive(8'h11, 0, 0); drive(8'h22, 0, 0);
    @(negedge clk);
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_wr, busy, cmd_addr, cmd_data, frame_cnt, err_cnt} !== 74'd0) begin
      errors++;
      $display("FAIL reset_mid: got wr=%b busy=%b addr=%h data=%h fc=%h ec=%h expected all zero",
               cmd_wr, busy, cmd_addr, cmd_data, frame_cnt, err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h33, 0, 0); drive(8'h44, 0, 1);
    gap(2);
    checks++;
    if (wr_seen != base || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_no_strobe: got strobes=%0d busy=%b expected 0 0", wr_seen - base, busy);
    end
    drive(8'hA5, 1, 0); drive(8'h81, 0, 0); drive(8'h00, 0, 0);
    drive(8'h00, 0, 0); drive(8'h00, 0, 0); drive(8'h07, 0, 1);
    gap(1);
    checks++;
    if (cmd_wr !== 1'b1 || cmd_addr !== 8'h81 || cmd_data !== 32'h00000007 ||
        frame_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_next: got wr=%b addr=%h data=%h fc=%0d ec=%0d expected 1 81 00000007 1 0",
               cmd_wr, cmd_addr, cmd_data, frame_cnt, err_cnt);
    end
  endtask

  task automatic test_err_saturation();
    gap(1);
    for (int i = 0; i < 65536; i++) drive(8'h00, 1, 1);
    gap(1);
    checks++;
    if (err_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL err_saturate: got %h expected ffff", err_cnt);
    end
    drive(8'hA5, 1, 0); drive(8'h5A, 1, 1);
    gap(1);
    checks++;
    if (err_cnt !== 16'hFFFF || frame_cnt !== 16'd1) begin
      errors++; $display("FAIL err_saturate_double: got ec=%h fc=%0d expected ffff 1", err_cnt, frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_record();
    test_gapped_records();
    test_bad_magic();
    test_truncated();
    test_mid_sop();
    test_double_err_and_no_revoke();
    test_clean_ends();
    test_reset_mid_frame();
    test_err_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_parser.md
CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001 The block SHALL have parameter MAGIC, default 8'hA5, the required first byte of every command frame.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_rx_data, input, 8 bits: received UDP payload byte.
REQ-005 The block SHALL have port i_rx_valid, input, 1 bit: i_rx_data/i_rx_sop/i_rx_eop are valid this cycle.
REQ-006 The block SHALL have port i_rx_sop, input, 1 bit: first byte of a payload, qualified by i_rx_valid.
REQ-007 The block SHALL have port i_rx_eop, input, 1 bit: last byte of a payload, qualified by i_rx_valid.
REQ-008 The block SHALL have port o_cmd_addr, output, 8 bits: register-write address to the command register block.
REQ-009 The block SHALL have port o_cmd_data, output, 32 bits: register-write data.
REQ-010 The block SHALL have port o_cmd_wr, output, 1 bit: one-cycle write strobe.
REQ-011 The block SHALL have port o_frame_cnt, output, 16 bits: count of frames completed without error, saturating.
REQ-012 The block SHALL have port o_err_cnt, output, 16 bits: count of malformed frames, saturating.
REQ-013 The block SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The frame format SHALL be: byte MAGIC, then zero or more 5-byte records; each record is addr[7:0], then data[31:24], data[23:16], data[15:8], data[7:0].
REQ-015 The state machine SHALL have states IDLE, ADDR, D3, D2, D1, D0 and DROP.
REQ-016 Bytes SHALL be consumed only in cycles with i_rx_valid=1, and the block SHALL accept every valid byte without back-pressure.
REQ-017 In IDLE, a valid byte without sop SHALL be ignored.
REQ-018 In IDLE, a valid sop byte equal to MAGIC SHALL move the state to ADDR, or stay in IDLE if eop is also set.
REQ-019 In IDLE, a valid sop byte not equal to MAGIC SHALL increment o_err_cnt and move the state to DROP, or stay in IDLE if eop is also set.
REQ-020 The record byte sequence SHALL advance ADDR->D3->D2->D1->D0, latching each byte into the matching address or data field.
REQ-021 A valid byte accepted in D0 SHALL complete the record, and the next state SHALL be ADDR, or IDLE if eop is set.
REQ-022 On completion of a record, o_cmd_wr SHALL be 1 for exactly the next cycle, with o_cmd_addr/o_cmd_data holding the record; latency from the D0 byte is 1 clock.
REQ-023 o_cmd_addr and o_cmd_data SHALL hold their last written values while o_cmd_wr=0.
REQ-024 A valid eop byte accepted in ADDR SHALL count as a clean frame end (frame of MAGIC plus N full records): o_frame_cnt increments and the state returns to IDLE.
REQ-025 A valid eop byte accepted in D0 SHALL count as a clean frame end: o_frame_cnt increments and the state returns to IDLE.
REQ-026 A lone MAGIC byte with sop and eop set together SHALL count as a clean frame end: o_frame_cnt increments.
REQ-027 A valid eop in D3, D2 or D1 SHALL discard the partial record with no strobe, increment o_err_cnt, and return the state to IDLE.
REQ-028 Records already written in the same frame SHALL NOT be revoked.
REQ-029 A valid sop in any state other than IDLE SHALL abort the current frame and increment o_err_cnt.
REQ-030 That sop byte SHALL then be processed as in IDLE, including a second o_err_cnt increment if it is not MAGIC.
REQ-031 DROP SHALL discard bytes until a valid eop, then go to IDLE; a sop in DROP is handled per REQ-029/REQ-030.
REQ-032 Both counters SHALL stop at 16'hFFFF.
REQ-033 When two increments of o_err_cnt occur in one cycle, it SHALL increase by 2, saturating.
REQ-034 A pulse stretched across cycles with i_rx_valid=0 SHALL behave identically to a contiguous one.

Reset
REQ-035 On rst_n low, asynchronously: state=IDLE, o_cmd_wr=0, o_cmd_addr=0, o_cmd_data=0, o_frame_cnt=0, o_err_cnt=0, o_busy=0.
REQ-036 A reset mid-frame SHALL discard the frame without a strobe or count; the first valid sop after release starts a new frame.

Verification
REQ-037 Frame A5,18,11,22,33,44 (sop on the first byte, eop on the last) -> one o_cmd_wr with addr=8'h18, data=32'h11223344 one clock after the last byte; o_frame_cnt=1.
REQ-038 Frame A5 + records (8'h28,32'hC0A80001),(8'h02,32'h00000001) with idle gaps -> two strobes in order; o_frame_cnt=1, o_err_cnt=0.
REQ-039 Frame 5A,.. through eop -> no strobe, o_err_cnt=1, state IDLE after eop; a following good frame is parsed normally.
REQ-040 Frame A5,30,01,02 with eop on the 4th byte -> no strobe, o_err_cnt=1, o_busy=0 next cycle.
REQ-041 Mid-record sop with A5 -> o_err_cnt+1, the new frame parses correctly; and 65536 bad frames -> o_err_cnt holds 16'hFFFF.
REQ-042 rst_n pulsed low after byte D2 of a record -> all outputs 0, no strobe, and a subsequent frame parses correctly.
